// File: rtl/uart_rx_framed.sv
// Oversampled UART receiver with optional parity, 1 or 2 stop bits, break detection
// and a single-word output register with valid/ready handshake and overrun flag.
module uart_rx_framed #(
   parameter int DBIT      = 8,
   parameter int OVS       = 16,
   parameter int PARITY_EN = 1,
   parameter int STOP_BITS = 1
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_rx,
   input  logic            i_s_tick,
   input  logic            i_par_odd,
   input  logic            i_ready,
   output logic [DBIT-1:0] o_data,
   output logic            o_valid,
   output logic            o_parity_err,
   output logic            o_frame_err,
   output logic            o_break,
   output logic            o_overrun,
   output logic            o_busy
);

   localparam int SW = $clog2(OVS);
   localparam int NW = $clog2(DBIT + 1);
   localparam logic [SW-1:0] S_HALF    = SW'(OVS / 2 - 1);
   localparam logic [SW-1:0] S_LAST    = SW'(OVS - 1);
   localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);
   localparam logic [NW-1:0] STOP_LAST = NW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   function automatic logic calc_parity(input logic [DBIT-1:0] d);
      return ^d;
   endfunction

   logic            rx_meta_r, rx_sync_r, rx_prev_r;
   state_t          state_r, state_next_s;
   logic [SW-1:0]   s_r, s_next_s;
   logic [NW-1:0]   n_r, n_next_s;
   logic [DBIT-1:0] shreg_r, shreg_next_s;
   logic            par_bit_r, par_bit_next_s;
   logic            ferr_r, ferr_next_s;
   logic            brk_r, brk_next_s;
   logic            done_s, fall_s, brk_now_s, par_err_s;
   logic [DBIT-1:0] data_r;
   logic            valid_r, perr_out_r, ferr_out_r, brk_out_r, ovr_out_r, busy_r;

   assign fall_s    = rx_prev_r & ~rx_sync_r;
   // Break needs an all-zero frame up to and including the first stop sample.
   assign brk_now_s = (shreg_r == {DBIT{1'b0}}) &&
                      ((PARITY_EN == 0) || (par_bit_r == 1'b0)) &&
                      (rx_sync_r == 1'b0);
   assign par_err_s = (PARITY_EN != 0) ? ((calc_parity(shreg_r) ^ par_bit_r) != i_par_odd) : 1'b0;

   // Line synchronizer and edge-detect history, idle-high out of reset.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
         rx_prev_r <= 1'b1;
      end else begin
         rx_meta_r <= i_rx;
         rx_sync_r <= rx_meta_r;
         rx_prev_r <= rx_sync_r;
      end
   end

   // FSM and frame datapath registers.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_r   <= ST_IDLE;
         s_r       <= {SW{1'b0}};
         n_r       <= {NW{1'b0}};
         shreg_r   <= {DBIT{1'b0}};
         par_bit_r <= 1'b0;
         ferr_r    <= 1'b0;
         brk_r     <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         s_r       <= s_next_s;
         n_r       <= n_next_s;
         shreg_r   <= shreg_next_s;
         par_bit_r <= par_bit_next_s;
         ferr_r    <= ferr_next_s;
         brk_r     <= brk_next_s;
         busy_r    <= (state_next_s != ST_IDLE);
      end
   end

   // Next-state and datapath update, sampling at mid-bit on oversampling ticks.
   always_comb begin
      state_next_s   = state_r;
      s_next_s       = s_r;
      n_next_s       = n_r;
      shreg_next_s   = shreg_r;
      par_bit_next_s = par_bit_r;
      ferr_next_s    = ferr_r;
      brk_next_s     = brk_r;
      done_s         = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (fall_s) begin
               state_next_s = ST_START;
               s_next_s     = {SW{1'b0}};
               n_next_s     = {NW{1'b0}};
               ferr_next_s  = 1'b0;
               brk_next_s   = 1'b0;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (!i_s_tick) begin
               s_next_s = s_r;
            end else if (s_r == S_HALF) begin
               s_next_s = {SW{1'b0}};
               if (rx_sync_r == 1'b0) begin
                  state_next_s = ST_DATA;
               end else begin
                  state_next_s = ST_IDLE;
               end
            end else begin
               s_next_s = s_r + SW'(1);
            end
         end
         ST_DATA: begin
            if (!i_s_tick) begin
               s_next_s = s_r;
            end else if (s_r == S_LAST) begin
               s_next_s     = {SW{1'b0}};
               shreg_next_s = {rx_sync_r, shreg_r[DBIT-1:1]};
               if (n_r == N_LAST) begin
                  n_next_s     = {NW{1'b0}};
                  state_next_s = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
               end else begin
                  n_next_s = n_r + NW'(1);
               end
            end else begin
               s_next_s = s_r + SW'(1);
            end
         end
         ST_PARITY: begin
            if (!i_s_tick) begin
               s_next_s = s_r;
            end else if (s_r == S_LAST) begin
               s_next_s       = {SW{1'b0}};
               par_bit_next_s = rx_sync_r;
               state_next_s   = ST_STOP;
            end else begin
               s_next_s = s_r + SW'(1);
            end
         end
         ST_STOP: begin
            if (!i_s_tick) begin
               s_next_s = s_r;
            end else if (s_r == S_LAST) begin
               s_next_s    = {SW{1'b0}};
               ferr_next_s = ferr_r | ~rx_sync_r;
               if (n_r == {NW{1'b0}}) begin
                  brk_next_s = brk_now_s;
               end else begin
                  brk_next_s = brk_r;
               end
               // Leave at the last stop sample so the next start edge is caught early.
               if (n_r == STOP_LAST) begin
                  state_next_s = ST_IDLE;
                  done_s       = 1'b1;
               end else begin
                  n_next_s = n_r + NW'(1);
               end
            end else begin
               s_next_s = s_r + SW'(1);
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Output word register: loads on completion, clears valid on consume.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         data_r     <= {DBIT{1'b0}};
         valid_r    <= 1'b0;
         perr_out_r <= 1'b0;
         ferr_out_r <= 1'b0;
         brk_out_r  <= 1'b0;
         ovr_out_r  <= 1'b0;
      end else if (done_s) begin
         data_r     <= shreg_r;
         valid_r    <= 1'b1;
         perr_out_r <= par_err_s;
         ferr_out_r <= ferr_next_s;
         brk_out_r  <= brk_next_s;
         ovr_out_r  <= valid_r & ~i_ready;
      end else if (valid_r && i_ready) begin
         valid_r <= 1'b0;
      end else begin
         valid_r <= valid_r;
      end
   end

   assign o_data       = data_r;
   assign o_valid      = valid_r;
   assign o_parity_err = perr_out_r;
   assign o_frame_err  = ferr_out_r;
   assign o_break      = brk_out_r;
   assign o_overrun    = ovr_out_r;
   assign o_busy       = busy_r;

endmodule
